// File: rtl/spi_xfer_arbiter_if.sv
// Bundle between the two requesters, the SPI arbiter and the SPI pins.
// The arbiter connects through the slave modport; requesters, bench and pins use master.
interface spi_xfer_arbiter_if #(
    parameter int unsigned DW = 16
);
    logic          req0;
    logic          req1;
    logic          sel0;
    logic          sel1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic          busy;
    logic          done;
    logic          done_id;
    logic [DW-1:0] rdata;
    logic          spi_cs1_l;
    logic          spi_cs2_l;
    logic          sclk;
    logic          mosi;
    logic          miso;

    modport slave (
        input  req0, req1, sel0, sel1, wdata0, wdata1, miso,
        output ack0, ack1, busy, done, done_id, rdata,
        output spi_cs1_l, spi_cs2_l, sclk, mosi
    );

    modport master (
        output req0, req1, sel0, sel1, wdata0, wdata1, miso,
        input  ack0, ack1, busy, done, done_id, rdata,
        input  spi_cs1_l, spi_cs2_l, sclk, mosi
    );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Two-requester arbiter and mode-0 SPI bit controller owning both chip selects.
// SPI_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module spi_xfer_arbiter #(
    parameter int unsigned HALF = 2,
    parameter int unsigned DW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    spi_xfer_arbiter_if.slave bus
);

    localparam int unsigned PW = 8;
    localparam int unsigned BW = 5;
    localparam logic [PW-1:0] PH_RELOAD = PW'(HALF - 1);
    localparam logic [BW-1:0] BIT_TOP   = BW'(DW - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          sclk_q, sclk_d;
    logic [DW-1:0] tx_q, tx_d;
    logic [DW-1:0] rx_q, rx_d;
    logic          id_q, id_d;
    logic          cs1_l_q, cs1_l_d;
    logic          cs2_l_q, cs2_l_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          done_id_q, done_id_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          win_c;
    logic          grant_c;
    logic          sel_c;
    logic [DW-1:0] wdata_c;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    // rr_q names the requester that wins the next tie
    logic rr_q, rr_d;

    assign win_c = (bus.req0 && bus.req1) ? rr_q : bus.req1;
    assign rr_d  = grant_c ? !win_c : rr_q;

    always_ff @(posedge clk) begin
        if (reset) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end
`else
    assign win_c = !bus.req0;
`endif

    assign grant_c = (state_q == S_IDLE) && !reset && (bus.req0 || bus.req1);
    assign sel_c   = win_c ? bus.sel1   : bus.sel0;
    assign wdata_c = win_c ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            id_q      <= 1'b0;
            cs1_l_q   <= 1'b1;
            cs2_l_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            id_q      <= id_d;
            cs1_l_q   <= cs1_l_d;
            cs2_l_q   <= cs2_l_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            rdata_q   <= rdata_d;
        end
    end

    // Every phase lasts HALF cycles: phase counter runs HALF-1 down to 0
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        id_d      = id_q;
        cs1_l_d   = cs1_l_q;
        cs2_l_d   = cs2_l_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_c) begin
                    state_d = S_SETUP;
                    phase_d = PH_RELOAD;
                    busy_d  = 1'b1;
                    id_d    = win_c;
                    tx_d    = wdata_c;
                    cs1_l_d = sel_c;
                    cs2_l_d = !sel_c;
                end
            end
            S_SETUP: begin
                if (phase_q == '0) begin
                    state_d = S_SHIFT;
                    phase_d = PH_RELOAD;
                    bit_d   = BIT_TOP;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            S_SHIFT: begin
                if (phase_q == '0) begin
                    phase_d = PH_RELOAD;
                    sclk_d  = !sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[DW-2:0], bus.miso};
                    end else begin
                        // falling edge: present the next bit, zero trails after bit 0
                        tx_d = {tx_q[DW-2:0], 1'b0};
                        if (bit_q == '0) state_d = S_HOLD;
                        else             bit_d   = bit_q - BW'(1);
                    end
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            S_HOLD: begin
                if (phase_q == '0) begin
                    state_d   = S_GAP;
                    phase_d   = PH_RELOAD;
                    cs1_l_d   = 1'b1;
                    cs2_l_d   = 1'b1;
                    done_d    = 1'b1;
                    rdata_d   = rx_q;
                    done_id_d = id_q;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            S_GAP: begin
                if (phase_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ack0      = grant_c && !win_c;
    assign bus.ack1      = grant_c && win_c;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.rdata     = rdata_q;
    assign bus.spi_cs1_l = cs1_l_q;
    assign bus.spi_cs2_l = cs2_l_q;
    assign bus.sclk      = sclk_q;
    assign bus.mosi      = tx_q[DW-1];

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: directed scenarios plus random requesters,
// checked every cycle against a transaction-timing model of the bus.
module tb_spi_xfer_arbiter;

    localparam int HALF = 2;
    localparam int DW   = 16;
    localparam int XFER = 1 + 35 * HALF;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic loop_en = 1'b1;
    logic miso_c  = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    logic        a0 = 1'b0, a1 = 1'b0, d0 = 1'b0;

    // reference model state
    bit          act       = 1'b0;
    int unsigned g         = 0;
    int unsigned idle_from = 0;
    logic [DW-1:0] m_wd    = '0;
    logic [DW-1:0] m_exp   = '0;
    logic [DW-1:0] m_rdata = '0;
    logic        m_id      = 1'b0;
    logic        m_did     = 1'b0;
    logic        m_sel     = 1'b0;
    logic        last_w    = 1'b1;
    bit          prev_rst  = 1'b0;

    spi_xfer_arbiter_if #(.DW(DW)) bus ();

    spi_xfer_arbiter #(.HALF(HALF), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.miso = loop_en ? bus.mosi : miso_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One cycle of the model: expected pins from the offset inside the current transfer
    task automatic model_cycle();
        bit   in_x;
        bit   grant;
        logic w;
        int   o;
        int   idx;
        in_x  = act && (cyc >= g + 1) && (cyc < g + XFER);
        o     = in_x ? int'(cyc - g - 1) : -1;
        grant = !reset && (cyc >= idle_from) && (bus.req0 || bus.req1);
`ifdef SPI_ARB_ROUND_ROBIN_EN
        if (bus.req0 && bus.req1) w = !last_w;
        else                      w = bus.req1;
`else
        w = bus.req0 ? 1'b0 : 1'b1;
`endif
        chk("ack0", 32'(bus.ack0), 32'(grant && !w));
        chk("ack1", 32'(bus.ack1), 32'(grant && w));
        chk("busy", 32'(bus.busy), 32'(in_x));
        chk("cs1_l", 32'(bus.spi_cs1_l), 32'(!(in_x && o < 34 * HALF && !m_sel)));
        chk("cs2_l", 32'(bus.spi_cs2_l), 32'(!(in_x && o < 34 * HALF && m_sel)));
        chk("sclk", 32'(bus.sclk),
            32'(in_x && o >= HALF && o < 33 * HALF && (((o - HALF) / HALF) % 2 == 1)));
        if (in_x && o == 34 * HALF) begin
            m_rdata = m_exp;
            m_did   = m_id;
        end
        chk("done", 32'(bus.done), 32'(in_x && o == 34 * HALF));
        chk("rdata", 32'(bus.rdata), 32'(m_rdata));
        chk("done_id", 32'(bus.done_id), 32'(m_did));
        if (in_x && o < 33 * HALF) begin
            idx = (o < HALF) ? 0 : (o - HALF) / (2 * HALF);
            chk("mosi", 32'(bus.mosi), 32'(m_wd[15 - idx]));
        end
        if (prev_rst) chk("mosi_rst", 32'(bus.mosi), 32'(0));

        prev_rst = reset;
        if (grant) begin
            act       = 1'b1;
            g         = cyc;
            m_id      = w;
            m_sel     = w ? bus.sel1 : bus.sel0;
            m_wd      = w ? bus.wdata1 : bus.wdata0;
            m_exp     = loop_en ? m_wd : {DW{miso_c}};
            idle_from = cyc + XFER;
            last_w    = w;
        end
        if (reset) begin
            act       = 1'b0;
            idle_from = cyc + 1;
            last_w    = 1'b1;
            m_rdata   = '0;
            m_did     = 1'b0;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        a0 = bus.ack0;
        a1 = bus.ack1;
        d0 = bus.done;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            step();
            got = a0 || a1;
        end
        if (!got) chk("ack_timeout", 32'(got), 32'(1));
    endtask

    task automatic drain(output int n_ack, output int n_done);
        n_ack  = 0;
        n_done = 0;
        repeat (XFER + 4) begin
            step();
            if (a0 || a1) n_ack++;
            if (d0) n_done++;
        end
    endtask

    initial begin
        bit            got;
        int            n, nd;
        int unsigned   gc[$];
        logic          gw[$];
        logic [DW-1:0] wd;

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.sel0 = 1'b0; bus.sel1 = 1'b0;
        bus.wdata0 = '0; bus.wdata1 = '0;
        repeat (3) step();
        reset = 1'b0;

        // single transfer to slave 1 with loopback
        loop_en = 1'b1;
        bus.sel0 = 1'b0; bus.wdata0 = 16'hA55A; bus.req0 = 1'b1;
        wait_ack(got);
        chk("A_ack0", 32'(a0), 32'(1));
        bus.req0 = 1'b0;
        drain(n, nd);
        chk("A_rdata", 32'(bus.rdata), 32'h0000_A55A);
        chk("A_done_id", 32'(bus.done_id), 32'(0));
        chk("A_extra_acks", 32'(n), 32'(0));

        // slave 2 target, miso tied high
        loop_en = 1'b0; miso_c = 1'b1;
        bus.sel1 = 1'b1; bus.wdata1 = 16'h0001; bus.req1 = 1'b1;
        wait_ack(got);
        chk("B_ack1", 32'(a1), 32'(1));
        bus.req1 = 1'b0;
        drain(n, nd);
        chk("B_rdata", 32'(bus.rdata), 32'h0000_FFFF);
        chk("B_done_id", 32'(bus.done_id), 32'(1));
        loop_en = 1'b1; miso_c = 1'b0;

        // contention over three transfers
        bus.sel0 = 1'b0; bus.sel1 = 1'b1;
        bus.wdata0 = DW'($urandom); bus.wdata1 = DW'($urandom);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(got);
            gc.push_back(cyc - 1);
            gw.push_back(a1);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
            chk("C_order", 32'(gw[k]), 32'((k == 1) ? 1 : 0));
`else
            chk("C_order", 32'(gw[k]), 32'(0));
`endif
            if (k > 0) chk("C_spacing", gc[k] - gc[k-1], 32'(XFER));
        end
        drain(n, nd);

        // reset asserted at bit 7 of a shift
        bus.sel0 = 1'b0; bus.wdata0 = DW'($urandom); bus.req0 = 1'b1;
        wait_ack(got);
        bus.req0 = 1'b0;
        repeat (17 * HALF) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("D_cs1_l", 32'(bus.spi_cs1_l), 32'(1));
        chk("D_cs2_l", 32'(bus.spi_cs2_l), 32'(1));
        chk("D_sclk", 32'(bus.sclk), 32'(0));
        chk("D_busy", 32'(bus.busy), 32'(0));
        chk("D_done", 32'(bus.done), 32'(0));
        drain(n, nd);
        chk("D_no_done", 32'(nd), 32'(0));
        wd = DW'($urandom);
        bus.sel1 = 1'b0; bus.wdata1 = wd; bus.req1 = 1'b1;
        wait_ack(got);
        bus.req1 = 1'b0;
        drain(n, nd);
        chk("D_after_rdata", 32'(bus.rdata), 32'(wd));
        chk("D_after_done", 32'(nd), 32'(1));

        // request withdrawn while the bus is busy
        bus.wdata0 = DW'($urandom); bus.req0 = 1'b1;
        wait_ack(got);
        bus.req0 = 1'b0;
        repeat (5) step();
        bus.req1 = 1'b1;
        step();
        bus.req1 = 1'b0;
        drain(n, nd);
        chk("E_acks", 32'(n), 32'(0));
        chk("E_done", 32'(nd), 32'(1));
        chk("E_busy", 32'(bus.busy), 32'(0));

        // random requesters with occasional reset
        for (int i = 0; i < 3000; i++) begin
            if (bus.req0 && a0)                             bus.req0 = ($urandom_range(0, 99) < 30);
            else if (bus.req0 && $urandom_range(0, 99) < 2) bus.req0 = 1'b0;
            else if (!bus.req0 && $urandom_range(0, 99) < 6) begin
                bus.req0 = 1'b1; bus.sel0 = 1'($urandom_range(0, 1)); bus.wdata0 = DW'($urandom);
            end
            if (bus.req1 && a1)                             bus.req1 = ($urandom_range(0, 99) < 30);
            else if (bus.req1 && $urandom_range(0, 99) < 2) bus.req1 = 1'b0;
            else if (!bus.req1 && $urandom_range(0, 99) < 6) begin
                bus.req1 = 1'b1; bus.sel1 = 1'($urandom_range(0, 1)); bus.wdata1 = DW'($urandom);
            end
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        drain(n, nd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
